vram_write_scheduler: RTL and testbench



---
 rtl/vram_sched_pkg.sv | 23 ++
 rtl/vram_clear_engine.sv | 65 ++++++
 rtl/vram_write_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_vram_write_scheduler.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_sched_pkg.sv
// Shared types and constants for the VRAM write-port scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vram_sched_pkg;

    // WAIT is only reachable when frame-synchronised clearing is built in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int HDISP     = 256;
    localparam int VDISP     = 240;
    localparam int PPU_DELAY = 3;

    // Frame-buffer address is row-major: {y, x}.
    function automatic logic [15:0] pack_addr(input logic [7:0] y, input logic [7:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/vram_clear_engine.sv
// Clear-screen address/colour generator: walks x then y over the visible frame.
// Latency: addr/data/last are combinational from the counters; start/advance act next cycle.
// Backpressure: advances only when the owner asserts advance; otherwise holds position.
// Ports: clk/reset; start (zero counters, latch color); advance (step one pixel);
//        addr/data (current clear write); last (current write is the final pixel).
module vram_clear_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int HDISP      = 256,
    parameter int VDISP      = 240
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] color,
    input  logic                  advance,
    output logic [15:0]           addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  last
);
    import vram_sched_pkg::*;

    logic [7:0]            x_q, x_d;
    logic [7:0]            y_q, y_d;
    logic [DATA_WIDTH-1:0] color_q, color_d;
    logic                  x_end;
    logic                  y_end;

    assign x_end = (x_q == 8'(HDISP - 1));
    assign y_end = (y_q == 8'(VDISP - 1));

    assign addr = pack_addr(y_q, x_q);
    assign data = color_q;
    assign last = x_end && y_end;

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        color_d = color_q;
        if (start) begin
            x_d     = 8'd0;
            y_d     = 8'd0;
            color_d = color;
        end else if (advance) begin
            if (x_end) begin
                x_d = 8'd0;
                y_d = y_end ? 8'd0 : y_q + 8'd1;
            end else begin
                x_d = x_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            color_q <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
        end
    end

endmodule

// File: rtl/vram_write_scheduler.sv
// Arbitrates the single VRAM write port between PPU pixels, a debug writer and a clear engine.
// Latency: one cycle; a decision in cycle t is on the registered outputs in cycle t+1.
// Backpressure: PPU never stalls (dropped during a clear); debug waits on req/ack; clear runs one write per cycle.
// Ports: clk_ppu/reset; ppu_* pixel stream; dbg_req/addr/data -> dbg_ack;
//        clr_start/clr_color -> clr_busy/clr_done; vram_addr/data/wren to VRAM port A.
// Build option: define VRAM_SCHED_FRAME_SYNC_EN to hold a requested clear until vblank start.
module vram_write_scheduler #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int HDISP      = 256,
    parameter int VDISP      = 240,
    parameter int PPU_DELAY  = 3
) (
    input  logic                  clk_ppu,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] ppu_pixel,
    input  logic [8:0]            ppu_hcnt,
    input  logic [8:0]            ppu_vcnt,
    input  logic                  ppu_en,
    input  logic                  dbg_req,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_data,
    output logic                  dbg_ack,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_color,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic [ADDR_WIDTH-1:0] vram_addr,
    output logic [DATA_WIDTH-1:0] vram_data,
    output logic                  vram_wren
);
    import vram_sched_pkg::*;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] vram_addr_q, vram_addr_d;
    logic [DATA_WIDTH-1:0] vram_data_q, vram_data_d;
    logic                  vram_wren_q, vram_wren_d;
    logic                  dbg_ack_q, dbg_ack_d;
    logic                  clr_busy_q, clr_busy_d;
    logic                  clr_done_q, clr_done_d;

    logic [8:0]            lsb;
    logic                  slot_vld;
    logic [ADDR_WIDTH-1:0] slot_addr;
    logic                  arb_en;
    logic                  dbg_blocked;

    logic                  eng_start;
    logic                  eng_advance;
    logic [15:0]           eng_addr;
    logic [DATA_WIDTH-1:0] eng_data;
    logic                  eng_last;

`ifdef VRAM_SCHED_FRAME_SYNC_EN
    logic                  vblank_start;
    assign vblank_start = (ppu_vcnt == 9'(VDISP)) && (ppu_hcnt == 9'd0);
`endif

    // hcnt runs ahead of the pixel it delivers; wrap in 9 bits so the first
    // few counts of a line land far above HDISP and never form a slot.
    assign lsb       = ppu_hcnt - 9'(PPU_DELAY);
    assign slot_vld  = ppu_en && (lsb < 9'(HDISP)) && (ppu_vcnt < 9'(VDISP));
    assign slot_addr = ADDR_WIDTH'(pack_addr(ppu_vcnt[7:0], lsb[7:0]));

    vram_clear_engine #(
        .DATA_WIDTH (DATA_WIDTH),
        .HDISP      (HDISP),
        .VDISP      (VDISP)
    ) u_clear (
        .clk     (clk_ppu),
        .reset   (reset),
        .start   (eng_start),
        .color   (clr_color),
        .advance (eng_advance),
        .addr    (eng_addr),
        .data    (eng_data),
        .last    (eng_last)
    );

    always_comb begin
        state_d     = state_q;
        vram_addr_d = vram_addr_q;
        vram_data_d = vram_data_q;
        vram_wren_d = 1'b0;
        dbg_ack_d   = 1'b0;
        clr_busy_d  = 1'b0;
        clr_done_d  = 1'b0;
        eng_start   = 1'b0;
        eng_advance = 1'b0;
        arb_en      = 1'b0;
        dbg_blocked = 1'b0;

        case (state_q)
            IDLE: begin
                arb_en = 1'b1;
                if (clr_start) begin
                    // A clear request wins over a coincident debug request,
                    // but the PPU pixel of this cycle is still written.
                    eng_start   = 1'b1;
                    clr_busy_d  = 1'b1;
                    dbg_blocked = 1'b1;
`ifdef VRAM_SCHED_FRAME_SYNC_EN
                    state_d     = WAIT;
`else
                    state_d     = CLEAR;
`endif
                end
            end
`ifdef VRAM_SCHED_FRAME_SYNC_EN
            WAIT: begin
                arb_en     = 1'b1;
                clr_busy_d = 1'b1;
                if (vblank_start) begin
                    state_d = CLEAR;
                end
            end
`endif
            CLEAR: begin
                vram_wren_d = 1'b1;
                vram_addr_d = ADDR_WIDTH'(eng_addr);
                vram_data_d = eng_data;
                eng_advance = 1'b1;
                clr_busy_d  = 1'b1;
                if (eng_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                arb_en     = 1'b1;
                clr_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (arb_en) begin
            if (slot_vld) begin
                vram_wren_d = 1'b1;
                vram_addr_d = slot_addr;
                vram_data_d = ppu_pixel;
            // Masking with the registered ack stops a second write while the
            // requester is still dropping req after seeing the ack.
            end else if (dbg_req && !dbg_ack_q && !dbg_blocked) begin
                vram_wren_d = 1'b1;
                vram_addr_d = dbg_addr;
                vram_data_d = dbg_data;
                dbg_ack_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_ppu) begin
        if (reset) begin
            state_q     <= IDLE;
            vram_addr_q <= '0;
            vram_data_q <= '0;
            vram_wren_q <= 1'b0;
            dbg_ack_q   <= 1'b0;
            clr_busy_q  <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            vram_addr_q <= vram_addr_d;
            vram_data_q <= vram_data_d;
            vram_wren_q <= vram_wren_d;
            dbg_ack_q   <= dbg_ack_d;
            clr_busy_q  <= clr_busy_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign vram_addr = vram_addr_q;
    assign vram_data = vram_data_q;
    assign vram_wren = vram_wren_q;
    assign dbg_ack   = dbg_ack_q;
    assign clr_busy  = clr_busy_q;
    assign clr_done  = clr_done_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler: PPU slots, debug handshake, clear, reset mid-clear.
// Inputs change 1 time unit after a rising edge; outputs are read at the same point,
// so each tick shows the registered result of the inputs applied before it.
module tb_vram_write_scheduler;

    logic        clk_ppu;
    logic        reset;
    logic [7:0]  ppu_pixel;
    logic [8:0]  ppu_hcnt;
    logic [8:0]  ppu_vcnt;
    logic        ppu_en;
    logic        dbg_req;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_data;
    logic        dbg_ack;
    logic        clr_start;
    logic [7:0]  clr_color;
    logic        clr_busy;
    logic        clr_done;
    logic [15:0] vram_addr;
    logic [7:0]  vram_data;
    logic        vram_wren;

    int checks;
    int failures;

    vram_write_scheduler dut (
        .clk_ppu   (clk_ppu),
        .reset     (reset),
        .ppu_pixel (ppu_pixel),
        .ppu_hcnt  (ppu_hcnt),
        .ppu_vcnt  (ppu_vcnt),
        .ppu_en    (ppu_en),
        .dbg_req   (dbg_req),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_ack   (dbg_ack),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .vram_wren (vram_wren)
    );

    initial clk_ppu = 1'b0;
    always #5 clk_ppu = ~clk_ppu;

    task automatic tick();
        @(posedge clk_ppu);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ppu_en    = 1'b1;
        ppu_vcnt  = 9'd10;
        ppu_hcnt  = 9'd3;
        ppu_pixel = 8'h55;
        dbg_req   = 1'b1;
        dbg_addr  = 16'h1111;
        dbg_data  = 8'h22;
        clr_start = 1'b1;
        clr_color = 8'h33;
        tick(); tick(); tick();
        checks++;
        if (vram_wren !== 1'b0) begin failures++; $display("FAIL reset_wren: got %b want 0", vram_wren); end
        checks++;
        if (vram_addr !== 16'h0000) begin failures++; $display("FAIL reset_addr: got %h want 0000", vram_addr); end
        checks++;
        if (vram_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", vram_data); end
        checks++;
        if (dbg_ack !== 1'b0) begin failures++; $display("FAIL reset_ack: got %b want 0", dbg_ack); end
        checks++;
        if (clr_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", clr_busy); end
        checks++;
        if (clr_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", clr_done); end
        clr_start = 1'b0;
        dbg_req   = 1'b0;
        ppu_en    = 1'b0;
        reset     = 1'b0;
        tick();
        checks++;
        if (vram_wren !== 1'b0 || clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idle: wren=%b busy=%b want 0 0", vram_wren, clr_busy);
        end
    endtask

    task automatic test_ppu_slot();
        // en, vcnt, hcnt, pixel, expected wren, expected addr
        logic        t_en   [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [8:0]  t_v    [9] = '{9'd10, 9'd10, 9'd10, 9'd10, 9'd10, 9'd240, 9'd239, 9'd10, 9'd0};
        logic [8:0]  t_h    [9] = '{9'd3, 9'd1, 9'd258, 9'd259, 9'd260, 9'd10, 9'd10, 9'd3, 9'd4};
        logic [7:0]  t_pix  [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h29};
        logic        t_wren [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] t_addr [9] = '{16'h0A00, 16'h0, 16'h0AFF, 16'h0, 16'h0, 16'h0, 16'hEF07, 16'h0, 16'h0001};
        dbg_req = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ppu_en    = t_en[i];
            ppu_vcnt  = t_v[i];
            ppu_hcnt  = t_h[i];
            ppu_pixel = t_pix[i];
            tick();
            checks++;
            if (vram_wren !== t_wren[i]) begin
                failures++;
                $display("FAIL ppu_wren[%0d]: got %b want %b", i, vram_wren, t_wren[i]);
            end else if (t_wren[i] && (vram_addr !== t_addr[i] || vram_data !== t_pix[i])) begin
                failures++;
                $display("FAIL ppu_write[%0d]: got %h/%h want %h/%h", i, vram_addr, vram_data, t_addr[i], t_pix[i]);
            end
        end
        ppu_en = 1'b0;
        tick();
    endtask

    task automatic test_dbg_blank();
        ppu_en   = 1'b1;
        ppu_vcnt = 9'd241;
        ppu_hcnt = 9'd100;
        dbg_req  = 1'b1;
        dbg_addr = 16'h1234;
        dbg_data = 8'h5A;
        tick();
        checks++;
        if (dbg_ack !== 1'b1 || vram_wren !== 1'b1 || vram_addr !== 16'h1234 || vram_data !== 8'h5A) begin
            failures++;
            $display("FAIL dbg_blank_first: ack=%b wren=%b %h/%h want 1 1 1234/5a", dbg_ack, vram_wren, vram_addr, vram_data);
        end
        tick();
        checks++;
        if (dbg_ack !== 1'b0 || vram_wren !== 1'b0) begin
            failures++;
            $display("FAIL dbg_blank_mask: ack=%b wren=%b want 0 0", dbg_ack, vram_wren);
        end
        tick();
        checks++;
        if (dbg_ack !== 1'b1 || vram_wren !== 1'b1) begin
            failures++;
            $display("FAIL dbg_blank_second: ack=%b wren=%b want 1 1", dbg_ack, vram_wren);
        end
        dbg_req = 1'b0;
        tick();
        checks++;
        if (dbg_ack !== 1'b0 || vram_wren !== 1'b0) begin
            failures++;
            $display("FAIL dbg_blank_release: ack=%b wren=%b want 0 0", dbg_ack, vram_wren);
        end
    endtask

    task automatic test_dbg_line();
        int first_h;
        logic [15:0] ack_addr;
        first_h  = -1;
        ack_addr = 16'h0;
        ppu_en   = 1'b1;
        ppu_vcnt = 9'd10;
        dbg_req  = 1'b1;
        dbg_addr = 16'h4321;
        dbg_data = 8'h99;
        for (int h = 250; h <= 262; h++) begin
            ppu_hcnt  = 9'(h);
            ppu_pixel = 8'(h);
            tick();
            if (dbg_ack === 1'b1 && first_h < 0) begin
                first_h  = h;
                ack_addr = vram_addr;
            end
        end
        checks++;
        if (first_h != 259) begin
            failures++;
            $display("FAIL dbg_line_ack_hcnt: got %0d want 259", first_h);
        end
        checks++;
        if (ack_addr !== 16'h4321) begin
            failures++;
            $display("FAIL dbg_line_addr: got %h want 4321", ack_addr);
        end
        dbg_req = 1'b0;
        ppu_en  = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        int acks;
        pat      = 6'b0;
        acks     = 0;
        ppu_en   = 1'b0;
        dbg_req  = 1'b1;
        dbg_addr = 16'h00AB;
        dbg_data = 8'h11;
        for (int i = 0; i < 6; i++) begin
            tick();
            pat = {pat[4:0], vram_wren};
            if (dbg_ack === 1'b1) acks++;
        end
        checks++;
        if (pat !== 6'b101010) begin
            failures++;
            $display("FAIL b2b_pattern: got %b want 101010", pat);
        end
        checks++;
        if (acks != 3) begin
            failures++;
            $display("FAIL b2b_acks: got %0d want 3", acks);
        end
        dbg_req = 1'b0;
        tick();
    endtask

    task automatic test_clear_collision();
        int errs;
        int first_bad;
        errs      = 0;
        first_bad = -1;
        ppu_en    = 1'b1;
        ppu_vcnt  = 9'd5;
        ppu_hcnt  = 9'd100;
        ppu_pixel = 8'hAA;
        dbg_req   = 1'b1;
        dbg_addr  = 16'h2222;
        dbg_data  = 8'h44;
        clr_start = 1'b1;
        clr_color = 8'h0F;
        tick();
        checks++;
        if (vram_wren !== 1'b1 || vram_addr !== 16'h0561 || vram_data !== 8'hAA || dbg_ack !== 1'b0 || clr_busy !== 1'b1) begin
            failures++;
            $display("FAIL clr_start_cycle: wren=%b %h/%h ack=%b busy=%b want 1 0561/aa 0 1",
                     vram_wren, vram_addr, vram_data, dbg_ack, clr_busy);
        end
        clr_start = 1'b0;
        clr_color = 8'hEE;
        for (int i = 0; i < 61440; i++) begin
            tick();
            if (vram_wren !== 1'b1 || vram_addr !== 16'(i) || vram_data !== 8'h0F ||
                dbg_ack !== 1'b0 || clr_busy !== 1'b1 || clr_done !== 1'b0) begin
                errs++;
                if (first_bad < 0) first_bad = i;
            end
            if (i == 61439) ppu_en = 1'b0;
        end
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL clear_sequence: %0d bad cycles, first at write %0d (addr %h data %h) want 0", errs, first_bad, vram_addr, vram_data);
        end
        tick();
        checks++;
        if (clr_done !== 1'b1 || clr_busy !== 1'b0) begin
            failures++;
            $display("FAIL clear_done: done=%b busy=%b want 1 0", clr_done, clr_busy);
        end
        checks++;
        if (dbg_ack !== 1'b1 || vram_wren !== 1'b1 || vram_addr !== 16'h2222 || vram_data !== 8'h44) begin
            failures++;
            $display("FAIL dbg_after_clear: ack=%b wren=%b %h/%h want 1 1 2222/44", dbg_ack, vram_wren, vram_addr, vram_data);
        end
        dbg_req = 1'b0;
        tick();
        checks++;
        if (clr_done !== 1'b0 || clr_busy !== 1'b0 || vram_wren !== 1'b0) begin
            failures++;
            $display("FAIL clear_idle_after: done=%b busy=%b wren=%b want 0 0 0", clr_done, clr_busy, vram_wren);
        end
    endtask

    task automatic test_reset_mid_clear();
        bit found;
        int bad;
        found     = 1'b0;
        bad       = 0;
        ppu_en    = 1'b0;
        dbg_req   = 1'b0;
        clr_start = 1'b1;
        clr_color = 8'h3C;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
            tick();
            if (vram_wren === 1'b1 && vram_addr === 16'd1000) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL reach_write_1000: got no write at 03e8 within 1100 cycles, want one");
        end
        reset = 1'b1;
        tick();
        checks++;
        if (vram_wren !== 1'b0 || vram_addr !== 16'h0 || vram_data !== 8'h0 ||
            clr_busy !== 1'b0 || clr_done !== 1'b0 || dbg_ack !== 1'b0) begin
            failures++;
            $display("FAIL mid_clear_reset: wren=%b %h/%h busy=%b done=%b ack=%b want all 0",
                     vram_wren, vram_addr, vram_data, clr_busy, clr_done, dbg_ack);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (clr_done !== 1'b0 || vram_wren !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL after_abort_quiet: got %0d cycles with done/wren, want 0", bad);
        end
        clr_start = 1'b1;
        clr_color = 8'h5D;
        tick();
        clr_start = 1'b0;
        checks++;
        if (clr_busy !== 1'b1) begin failures++; $display("FAIL restart_busy: got %b want 1", clr_busy); end
        tick();
        checks++;
        if (vram_wren !== 1'b1 || vram_addr !== 16'h0000 || vram_data !== 8'h5D) begin
            failures++;
            $display("FAIL restart_first: wren=%b %h/%h want 1 0000/5d", vram_wren, vram_addr, vram_data);
        end
        tick();
        checks++;
        if (vram_addr !== 16'h0001) begin failures++; $display("FAIL restart_second: got %h want 0001", vram_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_frame_sync();
        int bad;
        bad       = 0;
        ppu_en    = 1'b0;
        dbg_req   = 1'b0;
        ppu_vcnt  = 9'd50;
        ppu_hcnt  = 9'd0;
        clr_start = 1'b1;
        clr_color = 8'h66;
        tick();
        clr_start = 1'b0;
        checks++;
        if (clr_busy !== 1'b1 || vram_wren !== 1'b0) begin
            failures++;
            $display("FAIL sync_wait_entry: busy=%b wren=%b want 1 0", clr_busy, vram_wren);
        end
        for (int v = 51; v < 240; v++) begin
            ppu_vcnt = 9'(v);
            tick();
            if (vram_wren !== 1'b0 || clr_busy !== 1'b1) bad++;
        end
        ppu_vcnt = 9'd240;
        ppu_hcnt = 9'd5;
        tick();
        if (vram_wren !== 1'b0) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL sync_wait_hold: got %0d cycles writing or not busy, want 0", bad);
        end
        ppu_hcnt = 9'd0;
        tick();
        ppu_hcnt = 9'd1;
        tick();
        checks++;
        if (vram_wren !== 1'b1 || vram_addr !== 16'h0000 || vram_data !== 8'h66) begin
            failures++;
            $display("FAIL sync_first_write: wren=%b %h/%h want 1 0000/66", vram_wren, vram_addr, vram_data);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_ppu_slot();
        test_dbg_blank();
        test_dbg_line();
        test_back_to_back();
`ifdef VRAM_SCHED_FRAME_SYNC_EN
        test_frame_sync();
`else
        test_clear_collision();
        test_reset_mid_clear();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
